// File: rtl/score_bin_to_bcd.sv
// ============================================================================
// Module   : score_bin_to_bcd
// Brief    : Sequential double-dabble binary-to-BCD converter (four digits),
//            one shift-and-add-3 iteration per clock, start/done handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module score_bin_to_bcd #(
   parameter int BIN_WIDTH = 14,
   parameter int SAT_VALUE = 9999
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BIN_WIDTH-1:0] bin,
   input  logic                 start,
   output logic [15:0]          bcd,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow
);

   localparam int                 c_CNT_W = $clog2(BIN_WIDTH + 1);
   localparam logic [c_CNT_W-1:0] c_ITERS = c_CNT_W'(BIN_WIDTH);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
   localparam logic [BIN_WIDTH-1:0] c_SAT = BIN_WIDTH'(SAT_VALUE);

   // FINISH is folded into the last SHIFT edge, so only two encodings exist.
   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_load;
   logic                 w_step;
   logic                 w_finish;

   logic [BIN_WIDTH-1:0] r_bin;
   logic [15:0]          r_scr;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_ovf_int;
   logic [15:0]          r_bcd;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_ovf;

   logic                 w_over;
   logic [15:0]          w_adj;
   logic [15:0]          w_scr_nxt;
   logic [BIN_WIDTH-1:0] w_bin_nxt;
   logic                 w_unused;

   assign w_over = (32'(bin) > 32'd9999);

   generate
      for (genvar g = 0; g < 4; g++) begin : g_nib_adj
         assign w_adj[4*g +: 4] = (r_scr[4*g +: 4] >= 4'd5) ?
                                  (r_scr[4*g +: 4] + 4'd3) : r_scr[4*g +: 4];
      end
   endgenerate

   // The thousands digit never exceeds 9, so the bit shifted out of it is zero.
   assign w_scr_nxt = {w_adj[14:0], r_bin[BIN_WIDTH-1]};
   assign w_bin_nxt = {r_bin[BIN_WIDTH-2:0], 1'b0};
   assign w_unused  = w_adj[15];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_step = 1'b1;
            if (r_cnt == c_ONE) begin
               w_finish    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bin     <= '0;
         r_scr     <= '0;
         r_cnt     <= '0;
         r_ovf_int <= 1'b0;
         r_bcd     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_load) begin
            r_bin     <= w_over ? c_SAT : bin;
            r_ovf_int <= w_over;
            r_scr     <= '0;
            r_cnt     <= c_ITERS;
            r_busy    <= 1'b1;
         end
         if (w_step) begin
            r_scr <= w_scr_nxt;
            r_bin <= w_bin_nxt;
            r_cnt <= r_cnt - c_ONE;
         end
         // Result and flag are published together so the display never tears.
         if (w_finish) begin
            r_bcd  <= w_scr_nxt;
            r_ovf  <= r_ovf_int;
            r_done <= 1'b1;
            r_busy <= 1'b0;
         end
      end
   end

   assign bcd      = r_bcd;
   assign busy     = r_busy;
   assign done     = r_done;
   assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_score_bin_to_bcd.sv
// ============================================================================
// Module   : tb_score_bin_to_bcd
// Brief    : Directed bench with an arithmetic reference model for the
//            sequential binary-to-BCD converter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_score_bin_to_bcd;

   localparam int W = 14;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  bin   = '0;
   logic [15:0]   bcd;
   logic          busy;
   logic          done;
   logic          overflow;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   score_bin_to_bcd #(
      .BIN_WIDTH(W),
      .SAT_VALUE(9999)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .bin     (bin),
      .start   (start),
      .bcd     (bcd),
      .busy    (busy),
      .done    (done),
      .overflow(overflow)
   );

   // Decimal digits straight from integer division.
   function automatic logic [15:0] to_bcd(input int v);
      int c;
      c = (v > 9999) ? 9999 : v;
      return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
   endfunction

   // Timing model: a request accepted on edge n publishes its result on edge n+W.
   logic [15:0] m_bcd  = '0;
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic        m_ovf  = 1'b0;
   logic        m_pend = 1'b0;
   logic [15:0] m_res  = '0;
   logic        m_res_ovf = 1'b0;
   int          m_cyc  = 0;
   int          m_due  = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_bcd  <= '0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_ovf  <= 1'b0;
         m_pend <= 1'b0;
         m_cyc  <= 0;
      end else begin
         m_cyc  <= m_cyc + 1;
         m_done <= 1'b0;
         if (m_pend && (m_cyc + 1 == m_due)) begin
            m_bcd  <= m_res;
            m_ovf  <= m_res_ovf;
            m_done <= 1'b1;
            m_busy <= 1'b0;
            m_pend <= 1'b0;
         end else if (!m_pend && start) begin
            m_res     <= to_bcd(int'(bin));
            m_res_ovf <= (int'(bin) > 9999);
            m_due     <= m_cyc + 1 + W;
            m_pend    <= 1'b1;
            m_busy    <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if ({bcd, busy, done, overflow} !== {m_bcd, m_busy, m_done, m_ovf}) begin
         errors++;
         $display("FAIL model t=%0t: dut bcd=%h busy=%b done=%b ovf=%b, expected bcd=%h busy=%b done=%b ovf=%b",
                  $time, bcd, busy, done, overflow, m_bcd, m_busy, m_done, m_ovf);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Counts falling edges until done is seen, bounded.
   task automatic wait_done(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done && k < 60);
   endtask

   task automatic convert(input int b, input logic [15:0] eb, input logic eo, input string name);
      int k;
      bin   = W'(b);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(k);
      chk({name, " latency"}, k, W);
      chk({name, " bcd"}, bcd, eb);
      chk({name, " ovf"}, overflow, eo);
   endtask

   initial begin
      int k;
      int seen;
      #1 rst = 1'b0;
      start = 1'b1;
      bin   = W'(1234);
      repeat (3) @(negedge clk);
      chk("reset bcd", bcd, 16'h0000);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset ovf", overflow, 0);
      rst = 1'b1;
      convert(1234, 16'h1234, 1'b0, "nominal 1234");

      convert(0,     16'h0000, 1'b0, "bin 0");
      convert(9,     16'h0009, 1'b0, "bin 9");
      convert(10,    16'h0010, 1'b0, "bin 10");
      convert(9999,  16'h9999, 1'b0, "bin 9999");
      convert(12000, 16'h9999, 1'b1, "sat 12000");
      convert(42,    16'h0042, 1'b0, "after sat 42");

      // start held high: next request accepted right on the done cycle
      bin   = W'(7);
      start = 1'b1;
      @(negedge clk);
      wait_done(k);
      chk("held 7 latency", k, W);
      chk("held 7 bcd", bcd, 16'h0007);
      bin = W'(8);
      wait_done(k);
      start = 1'b0;
      chk("held 8 period", k, W + 1);
      chk("held 8 bcd", bcd, 16'h0008);

      // start pulsed mid-conversion is ignored
      @(negedge clk);
      bin   = W'(321);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      bin   = W'(999);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bin   = '0;
      wait_done(k);
      chk("ignored start latency", k + 5, W);
      chk("ignored start bcd", bcd, 16'h0321);

      // asynchronous reset mid-conversion
      @(negedge clk);
      bin   = W'(5555);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort bcd", bcd, 16'h0000);
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      repeat (3) @(negedge clk);
      rst  = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("abort no done", seen, 0);
      convert(88, 16'h0088, 1'b0, "after abort 88");

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
